maze_job_sched: RTL and testbench
=================================

// Module: maze_job_sched
// PURPOSE
//  Shares one maze-solver core between N_REQ requesters.
//  - Round-robin grants one requester at a time.
//  - Streams its 289-bit (17x17, row-major) map serially into the core.
//  - Waits for the core's path burst and routes the 2-bit moves back to the granted requester.
//  - Enforces the core's input gap rule and keeps in/out phases exclusive.
// PARAMETERS
//  N_REQ     2     number of requesters (2..8)
//  MAP_BITS  289   map length in bits, one bit per cycle
//  GAP_CYC   2     idle cycles before each load (core needs >=2)
//  TMO_CYC   4000  watchdog limit, WAIT+RUN cycles (TIMEOUT_EN only)
// PORTS
//  clk            in   1               clock, rising edge
//  rst            in   1               async reset, active-high
//  req            in   N_REQ           level request per requester
//  req_in         in   N_REQ           map bit per requester, valid when bit_rdy
//  gnt            out  N_REQ           one-hot grant, held for whole job
//  bit_rdy        out  1               granted requester's req_in is consumed this cycle
//  maze_in_valid  out  1               to core in_valid
//  maze_in        out  1               to core in
//  maze_out_valid in   1               from core out_valid
//  maze_out       in   2               from core out (00 R, 01 D, 10 L, 11 U)
//  rsp_valid      out  N_REQ           one-hot move valid to granted requester
//  rsp_dir        out  2               move code; 0 whenever rsp_valid==0
//  done           out  1               1-cycle pulse at job end
//  step_cnt       out  12              moves in last job; valid with done
//  tmo            out  1               1-cycle pulse on watchdog abort
// BEHAVIOUR
//  - Reset: all outputs 0; state IDLE; rr pointer=0; counters 0. Async, any state, mid-job included.
//  - IDLE: if |req, pick first set req at/after ptr (wrapping); next cycle gnt[sel]=1 -> GAP.
//  - GAP: GAP_CYC cycles, all core inputs 0 -> LOAD.
//  - LOAD: bit_rdy=1 for exactly MAP_BITS consecutive cycles.
//    - Same-cycle register: maze_in<=req_in[sel], maze_in_valid<=1 (1-cycle latency).
//    - maze_in_valid therefore high for exactly MAP_BITS cycles -> WAIT.
//  - WAIT: maze_in_valid=0, maze_in=0; on maze_out_valid=1 -> RUN.
//  - RUN: rsp_valid[sel]<=maze_out_valid, rsp_dir<=maze_out (1-cycle latency); step_cnt+=1 per valid.
//    - First cycle with maze_out_valid=0 -> done pulse next cycle.
//    - Also next cycle: gnt=0, ptr=sel+1 mod N_REQ -> IDLE.
//  - Core misbehaviour: maze_out_valid during LOAD/GAP is ignored (not forwarded); a maze_out value is forwarded only while maze_out_valid.
//  - req[sel] dropping while granted: ignored; job runs to completion, bit_rdy still driven.
//  - step_cnt saturates at 4095; cleared on entering GAP.
//  - Back-to-back jobs: min spacing done->next maze_in_valid = 1 (IDLE) + GAP_CYC cycles.
// CONFIGURATION
//  TIMEOUT_EN defined:
//    - 12-bit watchdog counts cycles in WAIT+RUN; cleared on entering WAIT.
//    - Reaching TMO_CYC: tmo pulse, no done, rsp_valid=0, gnt released, ptr advanced -> IDLE.
//  TIMEOUT_EN undefined: no watchdog; WAIT may last forever; tmo tied 0.
// STRUCTURE
//  Package maze_pkg:
//    - state enum {IDLE, GAP, LOAD, WAIT, RUN}.
//    - MAP_BITS=289, MAP_DIM=17.
//    - Direction codes DIR_R/D/L/U.
//  Sub-module rr_arbiter: N_REQ request vector + ptr -> one-hot pick + index. Combinational.
//  Top holds FSM, bit/gap/step/watchdog counters, output registers.
// TESTING
//  - Reset mid-LOAD (bit 100): all outputs 0 same cycle; after release, req=01 -> fresh GAP+289-bit load.
//  - req=11, ptr=0: gnt=01 first; after done, gnt=10 with no IDLE-skipped gap (GAP_CYC cycles seen).
//  - Map bits 0..288 from req_in[1]: maze_in_valid high exactly 289 cycles; maze_in equals req_in delayed 1 cycle.
//  - Core emits 32 moves: rsp_valid[sel] high 32 cycles, rsp_dir matches maze_out delayed 1, done with step_cnt=32.
//  - Core emits maze_out=3 with maze_out_valid=0 in WAIT: rsp_dir stays 0, rsp_valid stays 0.
//  - TIMEOUT_EN, core silent: tmo pulses exactly 4000 cycles after WAIT entry; next request granted.

Source files
------------

// File: rtl/maze_pkg.sv
// Shared types and constants for the maze-solver job scheduler.
package maze_pkg;

    localparam int unsigned MAP_DIM  = 17;
    localparam int unsigned MAP_BITS = MAP_DIM * MAP_DIM;
    localparam int unsigned STEP_W   = 12;
    localparam int unsigned WD_W     = 12;

    localparam logic [1:0] DIR_R = 2'b00;
    localparam logic [1:0] DIR_D = 2'b01;
    localparam logic [1:0] DIR_L = 2'b10;
    localparam logic [1:0] DIR_U = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        GAP,
        LOAD,
        WAIT,
        RUN
    } state_t;

    // Slot visited at offset 'off' when scanning n requesters starting from 'base'.
    function automatic int unsigned rr_slot(input int unsigned base, input int unsigned off,
                                            input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping.
module rr_arbiter
    import maze_pkg::*;
#(
    parameter int unsigned N_REQ = 2,
    parameter int unsigned IDX_W = 1
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = IDX_W'(rr_slot(32'(ptr), i, N_REQ));
            if (!found && req[cand]) begin
                found      = 1'b1;
                idx        = cand;
                pick[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/maze_job_sched.sv
// Shares one maze-solver core between N_REQ requesters: grant, serial map load, move routing.
// Optional watchdog abort of stuck jobs is built when TIMEOUT_EN is defined.
module maze_job_sched #(
    parameter int unsigned N_REQ    = 2,
    parameter int unsigned MAP_BITS = maze_pkg::MAP_BITS,
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned TMO_CYC  = 4000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_in,
    output logic [N_REQ-1:0] gnt,
    output logic             bit_rdy,
    output logic             maze_in_valid,
    output logic             maze_in,
    input  logic             maze_out_valid,
    input  logic [1:0]       maze_out,
    output logic [N_REQ-1:0] rsp_valid,
    output logic [1:0]       rsp_dir,
    output logic             done,
    output logic [11:0]      step_cnt,
    output logic             tmo
);
    import maze_pkg::*;

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BIT_W = $clog2(MAP_BITS);
    localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(MAP_BITS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'(GAP_CYC - 1);
    localparam logic [STEP_W-1:0] STEP_MAX = '1;

    state_t           st;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] ptr_next;
    logic [BIT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [N_REQ-1:0] pick;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_found;
    logic             wd_fire;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req   (req),
        .ptr   (ptr),
        .pick  (pick),
        .idx   (pick_idx),
        .found (pick_found)
    );

    assign ptr_next = (sel == IDX_W'(N_REQ - 1)) ? '0 : sel + IDX_W'(1);
    assign bit_rdy  = (st == LOAD);

`ifdef TIMEOUT_EN
    logic [WD_W-1:0] wd_cnt;

    // Held at zero during LOAD so the first WAIT cycle starts the count from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt <= '0;
        end else if (st == LOAD) begin
            wd_cnt <= '0;
        end else if (st == WAIT || st == RUN) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    assign wd_fire = (st == WAIT || st == RUN) && (wd_cnt == WD_W'(TMO_CYC - 1));
`else
    logic unused_tmo_cfg;
    assign unused_tmo_cfg = ^TMO_CYC;
    assign wd_fire        = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st            <= IDLE;
            ptr           <= '0;
            sel           <= '0;
            bit_cnt       <= '0;
            gap_cnt       <= '0;
            gnt           <= '0;
            maze_in_valid <= 1'b0;
            maze_in       <= 1'b0;
            rsp_valid     <= '0;
            rsp_dir       <= 2'b00;
            done          <= 1'b0;
            step_cnt      <= '0;
            tmo           <= 1'b0;
        end else begin
            maze_in_valid <= 1'b0;
            maze_in       <= 1'b0;
            rsp_valid     <= '0;
            rsp_dir       <= 2'b00;
            done          <= 1'b0;
            tmo           <= 1'b0;
            unique case (st)
                IDLE: begin
                    if (pick_found) begin
                        gnt      <= pick;
                        sel      <= pick_idx;
                        gap_cnt  <= '0;
                        step_cnt <= '0;
                        st       <= GAP;
                    end
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        bit_cnt <= '0;
                        st      <= LOAD;
                    end else begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                    end
                end
                LOAD: begin
                    maze_in_valid <= 1'b1;
                    maze_in       <= req_in[sel];
                    if (bit_cnt == BIT_LAST) begin
                        st <= WAIT;
                    end else begin
                        bit_cnt <= bit_cnt + BIT_W'(1);
                    end
                end
                WAIT, RUN: begin
                    // Watchdog wins over a move or an end-of-burst in the same cycle.
                    if (wd_fire) begin
                        tmo <= 1'b1;
                        gnt <= '0;
                        ptr <= ptr_next;
                        st  <= IDLE;
                    end else if (maze_out_valid) begin
                        rsp_valid <= gnt;
                        rsp_dir   <= maze_out;
                        if (step_cnt != STEP_MAX) begin
                            step_cnt <= step_cnt + STEP_W'(1);
                        end
                        st <= RUN;
                    end else if (st == RUN) begin
                        done <= 1'b1;
                        gnt  <= '0;
                        ptr  <= ptr_next;
                        st   <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_maze_job_sched.sv
// Self-checking bench for maze_job_sched: timeline model plus directed job scenarios.
module tb_maze_job_sched;

    localparam int N_REQ      = 2;
    localparam int MAP_BITS   = 289;
    localparam int GAP_CYC    = 2;
    localparam int TMO_CYC    = 4000;
    localparam int LOAD_FIRST = GAP_CYC + 1;
    localparam int LOAD_LAST  = GAP_CYC + MAP_BITS;
`ifdef TIMEOUT_EN
    localparam bit TMO_ON = 1'b1;
`else
    localparam bit TMO_ON = 1'b0;
`endif

    typedef struct {
        logic [1:0] g;
        int         idle;
        int         gap;
        int         miv;
        int         rv;
        int         steps;
        int         done;
    } job_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req = '0;
    logic [1:0]  req_in = '0;
    logic        mov = 1'b0;
    logic [1:0]  mo = '0;
    logic [1:0]  gnt;
    logic        bit_rdy;
    logic        maze_in_valid;
    logic        maze_in;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_dir;
    logic        done;
    logic [11:0] step_cnt;
    logic        tmo;

    int n_cmp = 0;
    int n_bad = 0;

    maze_job_sched #(
        .N_REQ    (N_REQ),
        .MAP_BITS (MAP_BITS),
        .GAP_CYC  (GAP_CYC),
        .TMO_CYC  (TMO_CYC)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_in         (req_in),
        .gnt            (gnt),
        .bit_rdy        (bit_rdy),
        .maze_in_valid  (maze_in_valid),
        .maze_in        (maze_in),
        .maze_out_valid (mov),
        .maze_out       (mo),
        .rsp_valid      (rsp_valid),
        .rsp_dir        (rsp_dir),
        .done           (done),
        .step_cnt       (step_cnt),
        .tmo            (tmo)
    );

    always #5 clk = ~clk;

    // Timeline model: a job is described by its grant cycle, its requester and its move count.
    bit          m_busy = 0;
    bit          m_started = 0;
    int          m_g = 0;
    int          m_sel = 0;
    int          m_ptr = 0;
    int          m_steps = 0;
    int          mcyc = 0;
    logic [1:0]  e_gnt = '0, e_rv = '0, e_rd = '0;
    logic        e_brdy = 0, e_miv = 0, e_mi = 0, e_done = 0, e_tmo = 0;
    logic [11:0] e_step = '0;

    always @(posedge clk or posedge rst) begin
        int age;
        if (rst) begin
            m_busy = 0; m_started = 0; m_ptr = 0; m_steps = 0; mcyc = 0;
            e_gnt = '0; e_rv = '0; e_rd = '0; e_brdy = 0; e_miv = 0; e_mi = 0;
            e_done = 0; e_tmo = 0; e_step = '0;
        end else begin
            e_done = 0; e_tmo = 0; e_miv = 0; e_mi = 0; e_rv = '0; e_rd = '0;
            if (!m_busy) begin
                for (int i = 0; i < N_REQ; i++) begin
                    if (!m_busy && req[(m_ptr + i) % N_REQ]) begin
                        m_busy = 1;
                        m_sel  = (m_ptr + i) % N_REQ;
                    end
                end
                if (m_busy) begin
                    m_g = mcyc; m_steps = 0; m_started = 0;
                end
            end else begin
                age = mcyc - m_g;
                if (age >= LOAD_FIRST && age <= LOAD_LAST) begin
                    e_miv = 1;
                    e_mi  = req_in[m_sel];
                end else if (age > LOAD_LAST) begin
                    if (TMO_ON && (age - LOAD_LAST == TMO_CYC)) begin
                        e_tmo = 1; m_busy = 0; m_ptr = (m_sel + 1) % N_REQ;
                    end else if (mov) begin
                        e_rv = 2'(1 << m_sel);
                        e_rd = mo;
                        if (m_steps < 4095) m_steps++;
                        m_started = 1;
                    end else if (m_started) begin
                        e_done = 1; m_busy = 0; m_ptr = (m_sel + 1) % N_REQ;
                    end
                end
            end
            e_gnt  = m_busy ? 2'(1 << m_sel) : 2'b00;
            e_brdy = m_busy && (mcyc + 1 - m_g >= LOAD_FIRST) && (mcyc + 1 - m_g <= LOAD_LAST);
            e_step = 12'(m_steps);
            mcyc++;
        end
    end

    always @(negedge clk) begin
        n_cmp++;
        if ({gnt, bit_rdy, maze_in_valid, maze_in, rsp_valid, rsp_dir, done, step_cnt, tmo} !==
            {e_gnt, e_brdy, e_miv, e_mi, e_rv, e_rd, e_done, e_step, e_tmo}) begin
            n_bad++;
            $display("FAIL cycle_model t=%0t: dut gnt=%b brdy=%b miv=%b mi=%b rv=%b rd=%b done=%b step=%0d tmo=%b | want gnt=%b brdy=%b miv=%b mi=%b rv=%b rd=%b done=%b step=%0d tmo=%b",
                     $time, gnt, bit_rdy, maze_in_valid, maze_in, rsp_valid, rsp_dir, done,
                     step_cnt, tmo, e_gnt, e_brdy, e_miv, e_mi, e_rv, e_rd, e_done, e_step, e_tmo);
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        req_in = 2'($urandom);
    endtask

    task automatic check_all_zero(input string name);
        check(name, int'({gnt, bit_rdy, maze_in_valid, maze_in, rsp_valid, rsp_dir, done,
                          step_cnt, tmo}), 0);
    endtask

    // Acts as the core for one job: junk drives out_valid noise in GAP/LOAD, drop releases req.
    task automatic run_job(input int moves, input int idle_cyc, input bit junk, input bit drop,
                           output job_t r);
        int t;
        r.idle = 0;
        t = 0;
        while (gnt == 2'b00 && t < 50) begin r.idle++; tick(); t++; end
        r.g = gnt;
        if (drop) req = 2'b00;
        r.gap = 0;
        t = 0;
        while (!bit_rdy && t < 50) begin
            r.gap++; mov = junk; mo = 2'd2; tick(); t++;
        end
        r.miv = 0;
        t = 0;
        while (t < 400) begin
            if (maze_in_valid) r.miv++;
            else if (r.miv > 0) break;
            mov = junk && bit_rdy && t[0];
            mo  = 2'(t);
            tick(); t++;
        end
        mov = 1'b0;
        for (int i = 0; i < idle_cyc; i++) begin
            mo = 2'd3;
            tick();
            check("wait_rsp_quiet", int'({rsp_valid, rsp_dir}), 0);
        end
        r.rv = 0;
        for (int i = 0; i < moves; i++) begin
            mov = 1'b1;
            mo  = 2'(i * 3 + (i >> 2));
            tick();
            if (rsp_valid != 2'b00) r.rv++;
        end
        mov = 1'b0;
        mo  = 2'd3;
        t = 0;
        while (!done && t < 20) begin tick(); t++; end
        r.done  = int'(done);
        r.steps = int'(step_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: still running at %0t, limit 2000000", $time);
        $fatal(1);
    end

    initial begin
        job_t r;
        int   t;
        int   n;
        rst = 1'b1;
        tick();
        tick();
        check_all_zero("reset_outputs");
        rst = 1'b0;

        // Reset in the middle of a load, then a clean job from requester 0.
        req = 2'b01;
        t = 0;
        while (!bit_rdy && t < 50) begin tick(); t++; end
        n = 0;
        t = 0;
        while (n < 100 && t < 200) begin if (bit_rdy) n++; tick(); t++; end
        check("midload_busy", int'(bit_rdy), 1);
        rst = 1'b1;
        #1;
        check_all_zero("midload_reset_outputs");
        tick();
        tick();
        rst = 1'b0;
        run_job(5, 3, 1'b0, 1'b0, r);
        check("job1_gnt", r.g, 1);
        check("job1_gap", r.gap, GAP_CYC);
        check("job1_miv_len", r.miv, 289);
        check("job1_rsp_count", r.rv, 5);
        check("job1_done", r.done, 1);
        check("job1_steps", r.steps, 5);
        req = 2'b00;

        // Both requesting from ptr=0: 01 first, then 10 after a single idle cycle.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req = 2'b11;
        run_job(32, 4, 1'b1, 1'b0, r);
        check("rr_first_gnt", r.g, 1);
        check("rr_first_miv_len", r.miv, 289);
        check("rr_first_rsp_count", r.rv, 32);
        check("rr_first_steps", r.steps, 32);
        run_job(7, 0, 1'b0, 1'b0, r);
        req = 2'b00;
        check("rr_second_idle", r.idle, 1);
        check("rr_second_gnt", r.g, 2);
        check("rr_second_gap", r.gap, GAP_CYC);
        check("rr_second_steps", r.steps, 7);

        // Requester 1 drops its request once granted; job still completes.
        req = 2'b10;
        run_job(3, 2, 1'b1, 1'b1, r);
        check("drop_gnt", r.g, 2);
        check("drop_miv_len", r.miv, 289);
        check("drop_done", r.done, 1);
        check("drop_steps", r.steps, 3);
        tick();
        check("drop_no_regrant", int'(gnt), 0);

`ifdef TIMEOUT_EN
        // Silent core: watchdog aborts, then the other requester is served.
        req = 2'b01;
        t = 0;
        while (!bit_rdy && t < 50) begin tick(); t++; end
        t = 0;
        while (bit_rdy && t < 400) begin tick(); t++; end
        n = 0;
        while (!tmo && n < 5000) begin tick(); n++; end
        check("tmo_latency", n, TMO_CYC);
        check("tmo_no_done", int'(done), 0);
        check("tmo_gnt_released", int'(gnt), 0);
        req = 2'b11;
        tick();
        check("tmo_next_gnt", int'(gnt), 2);
        req = 2'b00;
        rst = 1'b1;
        tick();
        rst = 1'b0;
`endif
        tick();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
